// File: rtl/video_timing_pkg.sv
// Mode constant sets and FSM state type shared by the video timing generator.
package video_timing_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vt_state_e;

    typedef struct packed {
        int unsigned sync;
        int unsigned bp;
        int unsigned act;
        int unsigned fp;
    } axis_timing_t;

    // Standard modes: sync / back porch / active / front porch per axis.
    localparam axis_timing_t M640X480_H  = '{sync: 96,  bp: 48,  act: 640,  fp: 16};
    localparam axis_timing_t M640X480_V  = '{sync: 2,   bp: 33,  act: 480,  fp: 10};
    localparam axis_timing_t M800X600_H  = '{sync: 128, bp: 88,  act: 800,  fp: 40};
    localparam axis_timing_t M800X600_V  = '{sync: 4,   bp: 23,  act: 600,  fp: 1};
    localparam axis_timing_t M1280X720_H = '{sync: 40,  bp: 220, act: 1280, fp: 110};
    localparam axis_timing_t M1280X720_V = '{sync: 5,   bp: 20,  act: 720,  fp: 5};

endpackage

// File: rtl/timing_axis_cnt.sv
// One timing axis: wrapping position counter plus sync, active and
// lead-shifted request window decodes.
module timing_axis_cnt #(
    parameter int unsigned SYNC  = 96,
    parameter int unsigned BP    = 48,
    parameter int unsigned ACT   = 640,
    parameter int unsigned FP    = 16,
    parameter int unsigned LEAD  = 0,
    parameter int unsigned CNT_W = $clog2(SYNC + BP + ACT + FP)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             step_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             last_c,
    output logic             sync_c,
    output logic             act_c,
    output logic             req_c
);

    localparam int unsigned TOT = SYNC + BP + ACT + FP;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TOT - 1);
    localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(SYNC);
    localparam logic [CNT_W-1:0] ACT_LO   = CNT_W'(SYNC + BP);
    localparam logic [CNT_W-1:0] ACT_HI   = CNT_W'(SYNC + BP + ACT - 1);
    localparam logic [CNT_W-1:0] REQ_LO   = CNT_W'(SYNC + BP - LEAD);
    localparam logic [CNT_W-1:0] REQ_HI   = CNT_W'(SYNC + BP + ACT - 1 - LEAD);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign last_c = (cnt_q == CNT_LAST);
    assign sync_c = (cnt_q < SYNC_END);
    assign act_c  = (cnt_q >= ACT_LO) && (cnt_q <= ACT_HI);
    assign req_c  = (cnt_q >= REQ_LO) && (cnt_q <= REQ_HI);

endmodule

// File: rtl/video_timing_gen.sv
// Parametrised video timing generator: sync, data-enable and pixel-request
// coordinates with frame-boundary start/stop and a frame counter.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned H_ACT    = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter int unsigned V_ACT    = 480,
    parameter int unsigned V_FP     = 10,
    parameter logic        HS_POL   = 1'b1,
    parameter logic        VS_POL   = 1'b1,
    parameter int unsigned REQ_LEAD = 1,
    parameter int unsigned COORD_W  = 10,
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FCNT_W   = 8
) (
    input  logic               vga_clk,
    input  logic               sys_rst_n,
    input  logic               en,
    input  logic [DATA_W-1:0]  pix_data,
    output logic               pix_req,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [DATA_W-1:0]  rgb,
    output logic               frame_start,
    output logic [FCNT_W-1:0]  frame_cnt
);

    localparam int unsigned H_TOT = H_SYNC + H_BP + H_ACT + H_FP;
    localparam int unsigned V_TOT = V_SYNC + V_BP + V_ACT + V_FP;
    localparam int unsigned H_CW  = $clog2(H_TOT);
    localparam int unsigned V_CW  = $clog2(V_TOT);
    localparam logic [H_CW-1:0] H_REQ_OFS = H_CW'(H_SYNC + H_BP - REQ_LEAD);
    localparam logic [V_CW-1:0] V_ACT_OFS = V_CW'(V_SYNC + V_BP);

    vt_state_e         state_q, state_d;
    logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic            run;
    logic [H_CW-1:0] h_cnt;
    logic [V_CW-1:0] v_cnt;
    logic            h_last, h_sync, h_act, h_req;
    logic            v_last, v_sync, v_act, v_req;

    assign run = (state_q == ST_RUN);

    timing_axis_cnt #(
        .SYNC (H_SYNC),
        .BP   (H_BP),
        .ACT  (H_ACT),
        .FP   (H_FP),
        .LEAD (REQ_LEAD),
        .CNT_W(H_CW)
    ) u_h_axis (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .clear_i(!run),
        .step_i (1'b1),
        .cnt_o  (h_cnt),
        .last_c (h_last),
        .sync_c (h_sync),
        .act_c  (h_act),
        .req_c  (h_req)
    );

    // Vertical axis has no lead: its request window equals its active window.
    timing_axis_cnt #(
        .SYNC (V_SYNC),
        .BP   (V_BP),
        .ACT  (V_ACT),
        .FP   (V_FP),
        .LEAD (0),
        .CNT_W(V_CW)
    ) u_v_axis (
        .clk    (vga_clk),
        .rst_n  (sys_rst_n),
        .clear_i(!run),
        .step_i (h_last),
        .cnt_o  (v_cnt),
        .last_c (v_last),
        .sync_c (v_sync),
        .act_c  (v_act),
        .req_c  (v_req)
    );

    // en is only honoured at the frame boundary so frames are never truncated.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (h_last && v_last) begin
                    frame_cnt_d = frame_cnt_q + FCNT_W'(1);
                    if (!en) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign hsync       = (run && h_sync) ? HS_POL : ~HS_POL;
    assign vsync       = (run && v_sync) ? VS_POL : ~VS_POL;
    assign de          = run && h_act && v_act;
    assign pix_req     = run && h_req && v_req;
    assign pix_x       = pix_req ? COORD_W'(h_cnt - H_REQ_OFS) : '1;
    assign pix_y       = pix_req ? COORD_W'(v_cnt - V_ACT_OFS) : '1;
    assign rgb         = de ? pix_data : '0;
    assign frame_start = run && (h_cnt == '0) && (v_cnt == '0);
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: small-mode instance against a frame-position
// model under directed and random en/reset, plus a 640x480 negative-polarity instance.
module tb_video_timing_gen;

    localparam int SH_TOT = 15;
    localparam int SF_TOT = 120;
    localparam int VG_H   = 800;
    localparam int VG_LINES_CHECKED = 37;

    logic vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    int checks = 0;
    int errors = 0;

    // Small-mode instance
    logic        sys_rst_n, en;
    logic [15:0] pix_data = 16'h0;
    logic        pix_req, hsync, vsync, de, frame_start;
    logic [9:0]  pix_x, pix_y;
    logic [15:0] rgb;
    logic [1:0]  frame_cnt;

    video_timing_gen #(
        .H_SYNC(2), .H_BP(3), .H_ACT(8), .H_FP(2),
        .V_SYNC(1), .V_BP(2), .V_ACT(4), .V_FP(1),
        .HS_POL(1'b1), .VS_POL(1'b1), .REQ_LEAD(1),
        .COORD_W(10), .DATA_W(16), .FCNT_W(2)
    ) dut (
        .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .en(en), .pix_data(pix_data),
        .pix_req(pix_req), .pix_x(pix_x), .pix_y(pix_y), .hsync(hsync),
        .vsync(vsync), .de(de), .rgb(rgb), .frame_start(frame_start),
        .frame_cnt(frame_cnt)
    );

    // 640x480, negative sync polarity
    logic        v_rst_n, v_en;
    logic [15:0] v_pix_data = 16'hA5A5;
    logic        v_pix_req, v_hsync, v_vsync, v_de, v_frame_start;
    logic [9:0]  v_pix_x, v_pix_y;
    logic [15:0] v_rgb;
    logic [7:0]  v_frame_cnt;

    video_timing_gen #(
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut_vga (
        .vga_clk(vga_clk), .sys_rst_n(v_rst_n), .en(v_en), .pix_data(v_pix_data),
        .pix_req(v_pix_req), .pix_x(v_pix_x), .pix_y(v_pix_y), .hsync(v_hsync),
        .vsync(v_vsync), .de(v_de), .rgb(v_rgb), .frame_start(v_frame_start),
        .frame_cnt(v_frame_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Source: answers each request with {y,x} one clock later.
    always @(posedge vga_clk)
        pix_data <= pix_req ? {pix_y[7:0], pix_x[7:0]} : 16'($urandom);

    // Model: position within the frame, running flag, completed frames.
    logic m_run = 1'b0;
    int   m_pos = 0;
    int   m_fcnt = 0;
    always @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            m_run <= 1'b0; m_pos <= 0; m_fcnt <= 0;
        end else if (!m_run) begin
            if (en) begin m_run <= 1'b1; m_pos <= 0; end
        end else if (m_pos == SF_TOT - 1) begin
            m_pos  <= 0;
            m_fcnt <= (m_fcnt + 1) % 4;
            if (!en) m_run <= 1'b0;
        end else begin
            m_pos <= m_pos + 1;
        end
    end

    always @(negedge vga_clk) begin
        int h, v;
        logic e_de, e_req;
        h     = m_pos % SH_TOT;
        v     = m_pos / SH_TOT;
        e_de  = m_run && h >= 5 && h <= 12 && v >= 3 && v <= 6;
        e_req = m_run && h >= 4 && h <= 11 && v >= 3 && v <= 6;
        chk("hsync", 32'(hsync), 32'(m_run && h < 2));
        chk("vsync", 32'(vsync), 32'(m_run && v < 1));
        chk("de", 32'(de), 32'(e_de));
        chk("pix_req", 32'(pix_req), 32'(e_req));
        chk("pix_x", 32'(pix_x), e_req ? 32'(h - 4) : 32'h3FF);
        chk("pix_y", 32'(pix_y), e_req ? 32'(v - 3) : 32'h3FF);
        chk("rgb", 32'(rgb), e_de ? 32'(((v - 3) << 8) | (h - 5)) : 32'h0);
        chk("frame_start", 32'(frame_start), 32'(m_run && m_pos == 0));
        chk("frame_cnt", 32'(frame_cnt), 32'(m_fcnt));
    end

    // 640x480 model and line-level tallies
    logic v_run = 1'b0;
    int   v_pos = 0;
    logic vga_done = 1'b0;
    int   hs_low_l0 = 0, vs_low_3l = 0, de_l34 = 0, de_l35 = 0;
    always @(posedge vga_clk or negedge v_rst_n) begin
        if (!v_rst_n) begin
            v_run <= 1'b0; v_pos <= 0;
        end else if (!v_run) begin
            if (v_en) begin v_run <= 1'b1; v_pos <= 0; end
        end else begin
            v_pos <= (v_pos + 1) % (VG_H * 525);
        end
    end

    always @(negedge vga_clk) begin
        int h, v;
        logic e_req, e_de;
        if (v_run && !vga_done) begin
            h     = v_pos % VG_H;
            v     = v_pos / VG_H;
            e_de  = h >= 144 && h <= 783 && v >= 35 && v <= 514;
            e_req = h >= 143 && h <= 782 && v >= 35 && v <= 514;
            chk("vga_hsync", 32'(v_hsync), 32'(!(h < 96)));
            chk("vga_vsync", 32'(v_vsync), 32'(!(v < 2)));
            chk("vga_de", 32'(v_de), 32'(e_de));
            chk("vga_rgb", 32'(v_rgb), e_de ? 32'hA5A5 : 32'h0);
            chk("vga_pix_req", 32'(v_pix_req), 32'(e_req));
            chk("vga_pix_x", 32'(v_pix_x), e_req ? 32'(h - 143) : 32'h3FF);
            chk("vga_pix_y", 32'(v_pix_y), e_req ? 32'(v - 35) : 32'h3FF);
            chk("vga_frame_start", 32'(v_frame_start), 32'(v_pos == 0));
            if (v == 0 && !v_hsync) hs_low_l0++;
            if (v < 3 && !v_vsync) vs_low_3l++;
            if (v == 34 && v_de) de_l34++;
            if (v == 35 && v_de) de_l35++;
            if (v_pos == VG_H * VG_LINES_CHECKED - 1) vga_done = 1'b1;
        end
    end

    task automatic drive_edge();
        @(posedge vga_clk);
        #2;
    endtask

    task automatic wait_fs(input string name, input int lim);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge vga_clk);
            if (frame_start === 1'b1) begin ok = 1'b1; break; end
        end
        chk(name, 32'(ok), 32'h1);
    endtask

    initial begin
        int exp_fc[5];
        int de_cnt;
        logic seen;
        logic [15:0] first_rgb;
        exp_fc = '{1, 2, 3, 0, 1};

        sys_rst_n = 1'b0; en = 1'b0; v_rst_n = 1'b0; v_en = 1'b0;
        repeat (2) @(negedge vga_clk);
        chk("rst_hsync", 32'(hsync), 32'h0);
        chk("rst_pix_x", 32'(pix_x), 32'h3FF);
        chk("rst_pix_y", 32'(pix_y), 32'h3FF);
        chk("rst_frame_cnt", 32'(frame_cnt), 32'h0);
        chk("rst_vga_hsync", 32'(v_hsync), 32'h1);
        chk("rst_vga_vsync", 32'(v_vsync), 32'h1);

        drive_edge();
        sys_rst_n = 1'b1; en = 1'b1; v_rst_n = 1'b1; v_en = 1'b1;
        wait_fs("first_frame_start", 5);
        chk("first_frame_cnt", 32'(frame_cnt), 32'h0);

        for (int f = 0; f < 5; f++) begin
            de_cnt = 0; seen = 1'b0; first_rgb = 16'hFFFF;
            repeat (SF_TOT) begin
                @(negedge vga_clk);
                if (de) begin
                    de_cnt++;
                    if (!seen) begin first_rgb = rgb; seen = 1'b1; end
                end
            end
            chk("fs_period_120", 32'(frame_start), 32'h1);
            chk("de_per_frame", 32'(de_cnt), 32'd32);
            chk("first_rgb", 32'(first_rgb), 32'h0);
            chk("frame_cnt_seq", 32'(frame_cnt), 32'(exp_fc[f]));
        end

        // Drop en on line 4: the frame must complete, then idle.
        repeat (63) @(negedge vga_clk);
        drive_edge();
        en = 1'b0;
        repeat (130) @(negedge vga_clk);
        chk("idle_hsync", 32'(hsync), 32'h0);
        chk("idle_vsync", 32'(vsync), 32'h0);
        chk("idle_de", 32'(de), 32'h0);
        chk("idle_pix_x", 32'(pix_x), 32'h3FF);
        chk("idle_frame_cnt", 32'(frame_cnt), 32'h2);
        drive_edge();
        en = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("restart_fs", 32'(frame_start), 32'h1);

        // Asynchronous reset at h=6, v=4 (inside active video).
        repeat (66) @(negedge vga_clk);
        chk("pre_rst_de", 32'(de), 32'h1);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("async_rst_de", 32'(de), 32'h0);
        chk("async_rst_hsync", 32'(hsync), 32'h0);
        chk("async_rst_pix_req", 32'(pix_req), 32'h0);
        chk("async_rst_frame_cnt", 32'(frame_cnt), 32'h0);
        drive_edge();
        sys_rst_n = 1'b1;
        repeat (2) @(negedge vga_clk);
        chk("post_rst_fs", 32'(frame_start), 32'h1);
        chk("post_rst_pix_x", 32'(pix_x), 32'h3FF);

        // Random en toggles and reset pulses until the 640x480 window is covered.
        for (int c = 0; c < 40000 && !vga_done; c++) begin
            drive_edge();
            if ($urandom_range(0, 99) < 2) en = ~en;
            if ($urandom_range(0, 999) == 0) begin
                sys_rst_n = 1'b0;
                drive_edge();
                sys_rst_n = 1'b1;
            end
        end
        chk("vga_window_reached", 32'(vga_done), 32'h1);
        chk("vga_hsync_low_per_line", 32'(hs_low_l0), 32'd96);
        chk("vga_vsync_low_2_lines", 32'(vs_low_3l), 32'd1600);
        chk("vga_de_line34", 32'(de_l34), 32'd0);
        chk("vga_de_line35", 32'(de_l35), 32'd640);
        chk("vga_frame_cnt", 32'(v_frame_cnt), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
